// File: rtl/lsu_defs.sv
// Shared definitions for the load/store sequencer: funct3 size codes, FSM states
// and the request fault check.
package lsu_defs;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR,
        ST_DONE
    } lsu_state_e;

    // A request faults on an unsupported size code or a misaligned halfword/word.
    function automatic logic is_fault(input logic write, input logic [2:0] funct3,
                                      input logic [1:0] lane);
        logic illegal;
        logic misaligned;
        illegal    = write ? (funct3 > F3_W) : (funct3 inside {3'b011, 3'b110, 3'b111});
        misaligned = 1'b0;
        case (funct3)
            F3_H, F3_HU: misaligned = lane[0];
            F3_W:        misaligned = |lane;
            default:     misaligned = 1'b0;
        endcase
        return illegal | misaligned;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Request, response and memory-port bundle of lsu_ctrl; slave is the sequencer's
// view, master the requester/memory side.
interface lsu_ctrl_if #(parameter int ADDR_W = 32);

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_fault;

    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_fault,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Lane steering for lsu_ctrl: load extract/extend and store merge or replicate.
// LSU_STORE_RMW_EN selects merged full-word stores instead of byte-enabled stores.
module lsu_lane_align
    import lsu_defs::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] rd_word,
    input  logic [31:0] merge_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word,
    output logic [3:0]  store_be
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    assign byte_val = rd_word[{lane, 3'b000} +: 8];
    assign half_val = rd_word[{lane[1], 4'b0000} +: 16];

    always_comb begin
        load_data = rd_word;
        case (funct3)
            F3_B:    load_data = {{24{byte_val[7]}}, byte_val};
            F3_BU:   load_data = {24'h0, byte_val};
            F3_H:    load_data = {{16{half_val[15]}}, half_val};
            F3_HU:   load_data = {16'h0, half_val};
            default: load_data = rd_word;
        endcase
    end

`ifdef LSU_STORE_RMW_EN
    // Sub-word stores patch the previously read word and write it back whole.
    always_comb begin
        store_be   = 4'hF;
        store_word = merge_word;
        case (funct3)
            F3_B:    store_word[{lane, 3'b000} +: 8]     = wdata[7:0];
            F3_H:    store_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: store_word = wdata;
        endcase
    end
`else
    logic [31:0] unused_merge;
    assign unused_merge = merge_word;

    // Sub-word stores replicate the data and let the byte enables pick the lane.
    always_comb begin
        store_be   = 4'hF;
        store_word = wdata;
        case (funct3)
            F3_B: begin
                store_be   = 4'b0001 << lane;
                store_word = {4{wdata[7:0]}};
            end
            F3_H: begin
                store_be   = 4'b0011 << {lane[1], 1'b0};
                store_word = {2{wdata[15:0]}};
            end
            default: begin
                store_be   = 4'hF;
                store_word = wdata;
            end
        endcase
    end
`endif

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the controller and the word-wide memory.
// Optional macro LSU_STORE_RMW_EN: byte/halfword stores use read-modify-write.
module lsu_ctrl
    import lsu_defs::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
)
(
    input logic       clk,
    input logic       rst,
    lsu_ctrl_if.slave bus
);

    if (DATA_W != 32) begin : g_data_w_check
        $error("lsu_ctrl: DATA_W must be 32");
    end

    lsu_state_e        state;
    lsu_state_e        state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        funct3_q;
    logic [31:0]       wdata_q;
    logic              write_q;
    logic              fault_q;
    logic [31:0]       word_q;
    logic [31:0]       rdata_q;

    logic              accept;
    logic              req_fault;
    logic [ADDR_W-1:0] word_addr;
    logic [31:0]       load_data;
    logic [31:0]       store_word;
    logic [3:0]        store_be;

    assign accept    = bus.req_valid && (state == ST_IDLE);
    assign req_fault = is_fault(bus.req_write, bus.req_funct3, bus.req_addr[1:0]);
    assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

    lsu_lane_align u_align (
        .funct3     (funct3_q),
        .lane       (addr_q[1:0]),
        .rd_word    (bus.mem_rdata),
        .merge_word (word_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word),
        .store_be   (store_be)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request fields are frozen at acceptance; memory data is captured in RD_DATA.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            funct3_q <= 3'b000;
            wdata_q  <= 32'h0;
            write_q  <= 1'b0;
            fault_q  <= 1'b0;
            word_q   <= 32'h0;
            rdata_q  <= 32'h0;
        end else begin
            if (accept) begin
                addr_q   <= bus.req_addr;
                funct3_q <= bus.req_funct3;
                wdata_q  <= bus.req_wdata;
                write_q  <= bus.req_write;
                fault_q  <= req_fault;
            end
            if (state == ST_RD_DATA) begin
                word_q <= bus.mem_rdata;
                if (!write_q) begin
                    rdata_q <= load_data;
                end
            end
        end
    end

    assign bus.resp_rdata = rdata_q;

    always_comb begin
        state_next     = state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_fault = 1'b0;
        bus.mem_en     = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_be     = 4'h0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = 32'h0;
        case (state)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (req_fault) begin
                        state_next = ST_DONE;
                    end else if (!bus.req_write) begin
                        state_next = ST_RD_ADDR;
                    end else if (bus.req_funct3 == F3_W) begin
                        state_next = ST_WR;
                    end else begin
`ifdef LSU_STORE_RMW_EN
                        state_next = ST_RD_ADDR;
`else
                        state_next = ST_WR;
`endif
                    end
                end
            end
            ST_RD_ADDR: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = word_addr;
                state_next   = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                state_next = write_q ? ST_WR : ST_DONE;
            end
            ST_WR: begin
                bus.mem_we    = 1'b1;
                bus.mem_be    = store_be;
                bus.mem_addr  = word_addr;
                bus.mem_wdata = store_word;
                state_next    = ST_DONE;
            end
            ST_DONE: begin
                bus.resp_valid = 1'b1;
                bus.resp_fault = fault_q;
                state_next     = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed vector table, multi-cycle corner
// sequences and randomized transactions against a behavioural memory/LSU model.
module tb_lsu_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [31:0] mem [256];
    logic [31:0] model_r;

    lsu_ctrl_if #(.ADDR_W(32)) bus ();

    lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory with one-cycle read latency and byte-enabled writes.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            bus.mem_rdata <= mem[bus.mem_addr[9:2]];
        end
        if (bus.mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_be[b]) mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
        end
    end

    typedef struct {
        logic        write;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] init_word;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        logic [31:0] exp_mem;
    } vec_t;

    vec_t vecs[15];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    function automatic int op_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic model_fault(input logic wr, input logic [2:0] f3, input logic [31:0] addr);
        logic legal;
        if (wr) legal = (f3 <= 3'd2);
        else    legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
        return !legal || ((addr % op_size(f3)) != 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        logic [31:0] mask;
        logic [31:0] v;
        sz   = op_size(f3);
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*sz)) - 32'd1);
        v    = (word >> (8 * (addr % 4))) & mask;
        if (f3 < 3'd4 && sz < 4 && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [2:0] f3,
                                                input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] v;
        int base;
        v    = old;
        base = int'(addr % 4);
        for (int i = 0; i < op_size(f3); i++) v[8*(base+i) +: 8] = wd[8*i +: 8];
        return v;
    endfunction

    task automatic applyStimulus(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd, output logic [31:0] rdata, output logic fault,
                                 output int lat, output int n_en, output int n_we, output logic [3:0] be,
                                 output logic [31:0] wword, output logic [31:0] maddr);
        int guard;
        rdata = 32'h0; fault = 1'b0; lat = 0; n_en = 0; n_we = 0;
        be = 4'h0; wword = 32'h0; maddr = 32'h0;
        @(negedge clk);
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        bus.req_write  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            if (bus.mem_en) begin
                n_en++;
                maddr = bus.mem_addr;
            end
            if (bus.mem_we) begin
                n_we++;
                be    = bus.mem_be;
                wword = bus.mem_wdata;
                maddr = bus.mem_addr;
            end
            if (bus.resp_valid) begin
                lat   = c;
                rdata = bus.resp_rdata;
                fault = bus.resp_fault;
            end
        end
    endtask

    // Runs one transaction and compares it with the expectations plus model-derived timing/strobes.
    task automatic checkTransaction(input string tag, input logic wr, input logic [2:0] f3,
                                    input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] init,
                                    input logic [31:0] exp_rdata, input logic exp_fault, input logic [31:0] exp_mem);
        logic [31:0] rdata, wword, maddr;
        logic        fault;
        logic [3:0]  be;
        int          lat, n_en, n_we, sz;
        int          e_lat, e_en, e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wword;
        bit          rmw;
`ifdef LSU_STORE_RMW_EN
        rmw = 1'b1;
`else
        rmw = 1'b0;
`endif
        sz = op_size(f3);
        mem[addr[9:2]] = init;
        applyStimulus(wr, f3, addr, wd, rdata, fault, lat, n_en, n_we, be, wword, maddr);

        if (exp_fault)       begin e_lat = 1; e_en = 0; e_we = 0; end
        else if (!wr)        begin e_lat = 3; e_en = 1; e_we = 0; end
        else if (sz == 4)    begin e_lat = 2; e_en = 0; e_we = 1; end
        else if (rmw)        begin e_lat = 4; e_en = 1; e_we = 1; end
        else                 begin e_lat = 2; e_en = 0; e_we = 1; end

        if (rmw || sz == 4) begin
            e_be    = 4'hF;
            e_wword = model_merge(init, f3, addr, wd);
        end else begin
            e_be    = 4'(((1 << sz) - 1) << (addr % 4));
            e_wword = (sz == 1) ? {4{wd[7:0]}} : {2{wd[15:0]}};
        end

        checkOutput({tag, " latency"}, 32'(lat), 32'(e_lat));
        checkOutput({tag, " fault"}, {31'h0, fault}, {31'h0, exp_fault});
        checkOutput({tag, " rdata"}, rdata, exp_rdata);
        checkOutput({tag, " mem_en count"}, 32'(n_en), 32'(e_en));
        checkOutput({tag, " mem_we count"}, 32'(n_we), 32'(e_we));
        checkOutput({tag, " mem word"}, mem[addr[9:2]], exp_mem);
        if (e_en + e_we > 0) checkOutput({tag, " mem_addr"}, maddr, {addr[31:2], 2'b00});
        if (e_we > 0) begin
            checkOutput({tag, " mem_be"}, {28'h0, be}, {28'h0, e_be});
            checkOutput({tag, " mem_wdata"}, wword, e_wword);
        end
    endtask

    initial begin
        logic [31:0] x_word, y_word;
        int          guard;
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        rst = 1'b1;

        vecs[0]  = '{1'b0, 3'b010, 32'h100, 32'h0,      32'h80FF_1234, 32'h80FF_1234, 1'b0, 32'h80FF_1234};
        vecs[1]  = '{1'b0, 3'b000, 32'h103, 32'h0,      32'h80FF_1234, 32'hFFFF_FF80, 1'b0, 32'h80FF_1234};
        vecs[2]  = '{1'b0, 3'b100, 32'h103, 32'h0,      32'h80FF_1234, 32'h0000_0080, 1'b0, 32'h80FF_1234};
        vecs[3]  = '{1'b0, 3'b001, 32'h102, 32'h0,      32'h80FF_1234, 32'hFFFF_80FF, 1'b0, 32'h80FF_1234};
        vecs[4]  = '{1'b0, 3'b101, 32'h100, 32'h0,      32'h80FF_1234, 32'h0000_1234, 1'b0, 32'h80FF_1234};
        vecs[5]  = '{1'b0, 3'b001, 32'h101, 32'h0,      32'h80FF_1234, 32'h0000_1234, 1'b1, 32'h80FF_1234};
        vecs[6]  = '{1'b1, 3'b010, 32'h102, 32'hDEAD,   32'h1122_3344, 32'h0000_1234, 1'b1, 32'h1122_3344};
        vecs[7]  = '{1'b0, 3'b011, 32'h100, 32'h0,      32'h80FF_1234, 32'h0000_1234, 1'b1, 32'h80FF_1234};
        vecs[8]  = '{1'b0, 3'b110, 32'h100, 32'h0,      32'h80FF_1234, 32'h0000_1234, 1'b1, 32'h80FF_1234};
        vecs[9]  = '{1'b1, 3'b000, 32'h101, 32'hAB,     32'h1122_3344, 32'h0000_1234, 1'b0, 32'h1122_AB44};
        vecs[10] = '{1'b1, 3'b001, 32'h102, 32'hBEEF,   32'h1122_3344, 32'h0000_1234, 1'b0, 32'hBEEF_3344};
        vecs[11] = '{1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0,       32'h0000_1234, 1'b0, 32'hDEAD_BEEF};
        vecs[12] = '{1'b1, 3'b100, 32'h108, 32'h55,     32'h0,         32'h0000_1234, 1'b1, 32'h0};
        vecs[13] = '{1'b0, 3'b101, 32'h106, 32'h0,      32'hF00D_0000, 32'h0000_F00D, 1'b0, 32'hF00D_0000};
        vecs[14] = '{1'b0, 3'b000, 32'h100, 32'h0,      32'h0000_007F, 32'h0000_007F, 1'b0, 32'h0000_007F};

        #12;
        checkOutput("reset req_ready", {31'h0, bus.req_ready}, 32'h1);
        checkOutput("reset resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        checkOutput("reset resp_fault", {31'h0, bus.resp_fault}, 32'h0);
        checkOutput("reset resp_rdata", bus.resp_rdata, 32'h0);
        checkOutput("reset mem strobes", {30'h0, bus.mem_en, bus.mem_we}, 32'h0);
        checkOutput("reset mem_be", {28'h0, bus.mem_be}, 32'h0);
        checkOutput("reset mem_addr", bus.mem_addr, 32'h0);
        checkOutput("reset mem_wdata", bus.mem_wdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            checkTransaction($sformatf("vec%0d", i), vecs[i].write, vecs[i].f3, vecs[i].addr,
                             vecs[i].wdata, vecs[i].init_word, vecs[i].exp_rdata,
                             vecs[i].exp_fault, vecs[i].exp_mem);
        end

        // req_valid held high with a changing address while the first load is in flight.
        x_word = 32'h1234_5678;
        y_word = 32'hCAFE_F00D;
        mem[32'h200 >> 2] = x_word;
        mem[32'h204 >> 2] = y_word;
        @(negedge clk);
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h200;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        #1 bus.req_addr = 32'h204;
        @(negedge clk);
        checkOutput("hold mem_addr first", bus.mem_addr, 32'h200);
        @(negedge clk);
        @(negedge clk);
        checkOutput("hold resp_valid first", {31'h0, bus.resp_valid}, 32'h1);
        checkOutput("hold rdata first", bus.resp_rdata, x_word);
        checkOutput("hold ready in DONE", {31'h0, bus.req_ready}, 32'h0);
        @(negedge clk);
        checkOutput("hold ready after DONE", {31'h0, bus.req_ready}, 32'h1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        checkOutput("hold mem_en second", {31'h0, bus.mem_en}, 32'h1);
        checkOutput("hold mem_addr second", bus.mem_addr, 32'h204);
        @(negedge clk);
        @(negedge clk);
        checkOutput("hold rdata second", bus.resp_rdata, y_word);

        // Reset during the WR cycle of a halfword store.
        mem[32'h302 >> 2] = 32'hA5A5_A5A5;
        @(negedge clk);
        bus.req_write  = 1'b1;
        bus.req_funct3 = 3'b001;
        bus.req_addr   = 32'h302;
        bus.req_wdata  = 32'h5555;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!bus.mem_we && guard < 6);
        checkOutput("rst-wr reached WR", {31'h0, bus.mem_we}, 32'h1);
        #1 rst = 1'b1;
        #1;
        checkOutput("rst-wr mem_we async drop", {31'h0, bus.mem_we}, 32'h0);
        checkOutput("rst-wr resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        guard = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.resp_valid) guard++;
        end
        checkOutput("rst-wr no response", 32'(guard), 32'h0);
        checkOutput("rst-wr ready after", {31'h0, bus.req_ready}, 32'h1);
        checkOutput("rst-wr mem untouched", mem[32'h302 >> 2], 32'hA5A5_A5A5);

        // Randomized transactions against the behavioural model.
        model_r = 32'h0;
        for (int i = 0; i < 80; i++) begin
            logic        wr, ef;
            logic [2:0]  f3;
            logic [31:0] addr, wd, init, emem;
            wr   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = 32'($urandom_range(0, 1023));
            wd   = $urandom;
            init = $urandom;
            ef   = model_fault(wr, f3, addr);
            emem = (wr && !ef) ? model_merge(init, f3, addr, wd) : init;
            if (!wr && !ef) model_r = model_load(init, f3, addr);
            checkTransaction($sformatf("rnd%0d", i), wr, f3, addr, wd, init, model_r, ef, emem);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
